booth2_mul_seq_pp_accumulator: RTL and testbench

- Iterative signed radix-4 Booth multiplier back end and consumer of the Booth-2 partial-product format {pp, s, e}.
- Accepts one operand pair over a valid/ready handshake. Each cycle it recodes one 3-bit Booth window of the multiplier and produces the matching partial product internally (standard Booth-2 generator encoding). It decodes that {pp, s, e} triple into a signed value and accumulates it at the correct weight.
- Used as the low-area alternative to the parallel Booth-2 array plus compressor tree.
- Delivers the full-width signed product over a second valid/ready handshake.

---
 rtl/booth2_mul_seq_pp_accumulator.sv | 155 +++++++++++++++
 tb/tb_booth2_mul_seq_pp_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/booth2_mul_seq_pp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : booth2_mul_seq_pp_accumulator
//  Description : Iterative signed radix-4 (Booth-2) multiplier. It retires
//                one Booth window per cycle. Each window is turned into a
//                {pp, s, e} partial-product triple, decoded to a signed
//                term, and added into a full-width accumulator at weight
//                4^k. Operands arrive and the product leaves over
//                valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth2_mul_seq_pp_accumulator #(
    parameter int MUL_IN_WD = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MUL_IN_WD-1:0]       ai_i,
    input  logic [MUL_IN_WD-1:0]       bi_i,
    input  logic                       in_vld_i,
    output logic                       in_rdy_o,
    output logic [2*MUL_IN_WD-1:0]     prod_o,
    output logic                       out_vld_o,
    input  logic                       out_rdy_i,
    output logic                       busy_o
);

    localparam int STEP_NUM = MUL_IN_WD / 2;
    localparam int PROD_WD  = 2 * MUL_IN_WD;
    localparam int c_K_WD   = $clog2(STEP_NUM);

    localparam logic [c_K_WD-1:0] c_K_LAST = c_K_WD'(STEP_NUM - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [MUL_IN_WD-1:0]   r_a;
    // Multiplier with the implicit b[-1]=0 appended. It is shifted right by
    // two every step, so the current Booth window always sits in r_b[2:0].
    logic [MUL_IN_WD:0]     r_b;
    logic [c_K_WD-1:0]      r_k;
    logic [PROD_WD-1:0]     r_acc;
    logic [PROD_WD-1:0]     r_prod;
    logic                   r_out_vld;

    logic [2:0]             w_win;
    logic [MUL_IN_WD-1:0]   w_a_dbl;
    // Only the low MUL_IN_WD bits of pp are kept. Bit MUL_IN_WD of the
    // generator output carries no extra information once e is known.
    logic [MUL_IN_WD-1:0]   w_pp;
    logic                   w_e;
    logic                   w_s;
    logic [PROD_WD-1:0]     w_term;
    logic [PROD_WD-1:0]     w_term_shl;
    logic [PROD_WD-1:0]     w_acc_nxt;
    logic                   w_in_rdy;

    assign w_win   = r_b[2:0];
    assign w_a_dbl = {r_a[MUL_IN_WD-2:0], 1'b0};
    assign w_s     = w_win[2];

    // Booth-2 partial-product generator: window -> {pp, e}
    always_comb begin
        w_pp = '0;
        w_e  = 1'b1;
        case (w_win)
            3'b000: begin
                w_pp = '0;
                w_e  = 1'b1;
            end
            3'b001, 3'b010: begin
                w_pp = r_a;
                w_e  = ~r_a[MUL_IN_WD-1];
            end
            3'b011: begin
                w_pp = w_a_dbl;
                w_e  = ~r_a[MUL_IN_WD-1];
            end
            3'b100: begin
                w_pp = ~w_a_dbl;
                w_e  = r_a[MUL_IN_WD-1];
            end
            3'b101, 3'b110: begin
                w_pp = ~r_a;
                w_e  = r_a[MUL_IN_WD-1];
            end
            default: begin
                w_pp = '1;
                w_e  = 1'b0;
            end
        endcase
    end

    // Decode pp + e*2^M - 2^M + s. The "e*2^M - 2^M" part is 0 when e=1 and
    // -2^M when e=0. So it becomes a fill of ~e above the pp bits. The
    // negation carry s is then added at the LSB.
    assign w_term     = {{(PROD_WD-MUL_IN_WD){~w_e}}, w_pp} + PROD_WD'(w_s);
    assign w_term_shl = w_term << {r_k, 1'b0};
    assign w_acc_nxt  = r_acc + w_term_shl;

    assign w_in_rdy  = (r_state == c_ST_IDLE);
    assign in_rdy_o  = w_in_rdy;
    assign busy_o    = (r_state != c_ST_IDLE);
    assign out_vld_o = r_out_vld;
    assign prod_o    = r_prod;

    // Control FSM, operand capture, per-step accumulation and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_prod    <= '0;
            r_out_vld <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_vld_i && w_in_rdy) begin
                        r_a     <= ai_i;
                        r_b     <= {bi_i, 1'b0};
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_state <= c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= {2'b00, r_b[MUL_IN_WD:2]};
                    if (r_k == c_K_LAST) begin
                        r_prod    <= w_acc_nxt;
                        r_out_vld <= 1'b1;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_k <= r_k + c_K_WD'(1);
                    end
                end
                c_ST_DONE: begin
                    if (out_rdy_i) begin
                        r_out_vld <= 1'b0;
                        r_state   <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_out_vld <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth2_mul_seq_pp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth2_mul_seq_pp_accumulator
//  Description : Directed self-checking bench for the iterative Booth-2
//                multiplier. Covers reset, basic and extreme products,
//                back-pressure, abort by reset and a batch of random pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth2_mul_seq_pp_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ai;
    logic [31:0] bi;
    logic        in_vld;
    logic        in_rdy;
    logic [63:0] prod;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    booth2_mul_seq_pp_accumulator #(.MUL_IN_WD(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ai_i      (ai),
        .bi_i      (bi),
        .in_vld_i  (in_vld),
        .in_rdy_o  (in_rdy),
        .prod_o    (prod),
        .out_vld_o (out_vld),
        .out_rdy_i (out_rdy),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and return just after the accepting edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        while (!in_rdy && guard < 100) begin
            tick();
            guard++;
        end
        check("launch_rdy", 64'(in_rdy), 64'd1);
        in_vld = 1'b1;
        ai     = a;
        bi     = b;
        tick();
        in_vld = 1'b0;
        ai     = 32'hDEAD_BEEF;
        bi     = 32'h1234_5678;
    endtask

    // Count cycles from the accepting edge until out_vld rises (bounded)
    task automatic wait_vld(output int cyc);
        cyc = 0;
        while (!out_vld && cyc < 100) begin
            tick();
            cyc++;
        end
        check("vld_timeout", 64'(out_vld), 64'd1);
    endtask

    // Full operation with out_rdy already high
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int lat;
        out_rdy = 1'b1;
        launch(a, b);
        wait_vld(lat);
        check({tag, "_lat"}, 64'(lat), 64'd16);
        check({tag, "_prod"}, prod, exp);
        tick();
        check({tag, "_vld_fall"}, 64'(out_vld), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        int sa;
        int sb;
        longint ref_p;
        int stall;

        // Reset held for two edges with in_vld asserted
        rst     = 1'b1;
        in_vld  = 1'b1;
        ai      = 32'd3;
        bi      = 32'd4;
        out_rdy = 1'b1;
        tick();
        tick();
        check("rst_in_rdy",  64'(in_rdy),  64'd1);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_prod",    prod,         64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        rst    = 1'b0;
        in_vld = 1'b0;
        tick();
        check("post_rst_busy", 64'(busy), 64'd0);

        // Basic: 7 * -3
        launch(32'd7, 32'hFFFF_FFFD);
        check("basic_busy",   64'(busy),   64'd1);
        check("basic_in_rdy", 64'(in_rdy), 64'd0);
        wait_vld(lat);
        check("basic_lat",  64'(lat), 64'd16);
        check("basic_prod", prod,     64'hFFFF_FFFF_FFFF_FFEB);
        tick();
        check("basic_vld_fall", 64'(out_vld), 64'd0);
        check("basic_rdy_back", 64'(in_rdy),  64'd1);
        check("basic_hold",     prod,         64'hFFFF_FFFF_FFFF_FFEB);

        // Extremes and zero / minus-one multipliers
        run_op("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("maxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_op("neg1",   32'd5,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op("azero",  32'd0,         32'h1234_5678, 64'd0);
        run_op("bzero",  32'h8765_4321, 32'd0,         64'd0);
        run_op("m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        run_op("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

        // Back-pressure: product held for 10 cycles, input pulses ignored
        out_rdy = 1'b0;
        launch(32'd123456, -32'sd654321);
        wait_vld(lat);
        check("bp_lat",  64'(lat), 64'd16);
        check("bp_prod", prod,     64'(-64'sd80779853376));
        held = prod;
        for (int i = 0; i < 10; i++) begin
            in_vld = i[0];
            ai     = 32'd11;
            bi     = 32'd13;
            tick();
            check("bp_vld_hold",  64'(out_vld), 64'd1);
            check("bp_prod_hold", prod,         64'(-64'sd80779853376));
            check("bp_in_rdy",    64'(in_rdy),  64'd0);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        tick();
        check("bp_vld_fall", 64'(out_vld), 64'd0);
        check("bp_rdy_back", 64'(in_rdy),  64'd1);
        check("bp_prod_end", prod,         held);
        tick();
        check("bp_idle", 64'(busy), 64'd0);

        // Abort: reset partway through CALC yields no output
        launch(32'd9, 32'd9);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_vld",    64'(out_vld), 64'd0);
        check("abort_in_rdy", 64'(in_rdy),  64'd1);
        check("abort_busy",   64'(busy),    64'd0);
        check("abort_prod",   prod,         64'd0);
        seen = 0;
        repeat (30) begin
            tick();
            if (out_vld) seen++;
        end
        check("abort_no_out", 64'(seen), 64'd0);
        run_op("after_abort", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);

        // Random signed pairs with random downstream stalls
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 17 == 0) ra = 32'h8000_0000;
            if (i % 23 == 0) rb = 32'hFFFF_FFFF;
            sa    = ra;
            sb    = rb;
            ref_p = longint'(sa) * longint'(sb);
            out_rdy = 1'($urandom_range(0, 1));
            launch(ra, rb);
            wait_vld(lat);
            check("rnd_lat",  64'(lat), 64'd16);
            check("rnd_prod", prod,     64'(ref_p));
            out_rdy = 1'b0;
            stall   = $urandom_range(0, 3);
            repeat (stall) tick();
            check("rnd_vld_hold", 64'(out_vld), 64'd1);
            out_rdy = 1'b1;
            tick();
            check("rnd_vld_fall", 64'(out_vld), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
